// File: rtl/mem_pkg.sv
// Shared types and constants for the memory pipeline stage and its MEM/WB register.
package mem_pkg;
    localparam int DATA_W         = 32;
    localparam int WB_CTL_W       = 2;
    localparam int REG_W          = 5;
    localparam int CNT_W          = 4;
    localparam int TIMEOUT_CYCLES = 15;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    function automatic logic word_aligned(input logic [1:0] addr_lsb);
        return addr_lsb == 2'b00;
    endfunction
endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register: one-cycle valid pulse per load, fields hold otherwise.
module mem_wb_reg
    import mem_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic                squash,
    input  logic [WB_CTL_W-1:0] ctl_next,
    input  logic [DATA_W-1:0]   rdata_next,
    input  logic [DATA_W-1:0]   alu_next,
    input  logic [REG_W-1:0]    dst_next,
    output logic                valid,
    output logic [WB_CTL_W-1:0] ctl,
    output logic [DATA_W-1:0]   rdata,
    output logic [DATA_W-1:0]   alu,
    output logic [REG_W-1:0]    dst
);
    logic                valid_reg;
    logic [WB_CTL_W-1:0] ctl_reg;
    logic [DATA_W-1:0]   rdata_reg;
    logic [DATA_W-1:0]   alu_reg;
    logic [REG_W-1:0]    dst_reg;

    // A squashed entry still retires, but must not write the register file.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_reg <= 1'b0;
            ctl_reg   <= '0;
            rdata_reg <= '0;
            alu_reg   <= '0;
            dst_reg   <= '0;
        end else begin
            valid_reg <= load;
            if (load) begin
                ctl_reg   <= squash ? '0 : ctl_next;
                rdata_reg <= squash ? '0 : rdata_next;
                alu_reg   <= alu_next;
                dst_reg   <= dst_next;
            end
        end
    end

    assign valid = valid_reg;
    assign ctl   = ctl_reg;
    assign rdata = rdata_reg;
    assign alu   = alu_reg;
    assign dst   = dst_reg;
endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: data-memory request/ack FSM with a wait-cycle timeout,
// stalling earlier stages while an access is outstanding.
module mem_stage
    import mem_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    input  logic [WB_CTL_W-1:0] wb_ctlout,
    input  logic                branch,
    input  logic                memread,
    input  logic                memwrite,
    input  logic                zero,
    input  logic [DATA_W-1:0]   alu_result,
    input  logic [DATA_W-1:0]   rdata2out,
    input  logic [REG_W-1:0]    five_bit_muxout,
    output logic                stall,
    output logic                pcsrc,
    output logic                dmem_req,
    output logic                dmem_we,
    output logic [DATA_W-1:0]   dmem_addr,
    output logic [DATA_W-1:0]   dmem_wdata,
    input  logic [DATA_W-1:0]   dmem_rdata,
    input  logic                dmem_ack,
    output logic                wb_valid,
    output logic [WB_CTL_W-1:0] wb_ctl,
    output logic [DATA_W-1:0]   read_data,
    output logic [DATA_W-1:0]   alu_q,
    output logic [REG_W-1:0]    write_reg,
    output logic                align_err,
    output logic                timeout_err
);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t              state_reg;
    logic [CNT_W-1:0]    count_reg;
    logic                req_reg;
    logic                we_reg;
    logic [DATA_W-1:0]   addr_reg;
    logic [DATA_W-1:0]   wdata_reg;
    logic [WB_CTL_W-1:0] pend_ctl_reg;
    logic [REG_W-1:0]    pend_dst_reg;
    logic                align_err_reg;
    logic                timeout_err_reg;

    logic is_idle;
    logic is_wait;
    logic single_op;
    logic both_op;
    logic start_access;
    logic ack_seen;
    logic expire;

    logic                wb_load;
    logic                wb_squash;
    logic [WB_CTL_W-1:0] wb_ctl_next;
    logic [DATA_W-1:0]   wb_rdata_next;
    logic [DATA_W-1:0]   wb_alu_next;
    logic [REG_W-1:0]    wb_dst_next;

    assign is_idle      = (state_reg == ST_IDLE);
    assign is_wait      = (state_reg == ST_WAIT);
    assign single_op    = in_valid & (memread ^ memwrite);
    assign both_op      = in_valid & memread & memwrite;
    assign start_access = is_idle & single_op & word_aligned(alu_result[1:0]);
    assign ack_seen     = is_wait & dmem_ack;
    // The fifteenth WAIT cycle without ack is the last one; an ack there still wins.
    assign expire       = is_wait & ~dmem_ack & (count_reg == CNT_LAST);

    assign stall = start_access | (is_wait & ~dmem_ack);
    assign pcsrc = is_idle & in_valid & branch & zero;

    assign dmem_req    = req_reg;
    assign dmem_we     = we_reg;
    assign dmem_addr   = addr_reg;
    assign dmem_wdata  = wdata_reg;
    assign align_err   = align_err_reg;
    assign timeout_err = timeout_err_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg       <= ST_IDLE;
            count_reg       <= '0;
            req_reg         <= 1'b0;
            we_reg          <= 1'b0;
            addr_reg        <= '0;
            wdata_reg       <= '0;
            pend_ctl_reg    <= '0;
            pend_dst_reg    <= '0;
            align_err_reg   <= 1'b0;
            timeout_err_reg <= 1'b0;
        end else begin
            unique case (state_reg)
                ST_IDLE: begin
                    if (start_access) begin
                        state_reg    <= ST_WAIT;
                        count_reg    <= '0;
                        req_reg      <= 1'b1;
                        we_reg       <= memwrite;
                        addr_reg     <= alu_result;
                        wdata_reg    <= rdata2out;
                        pend_ctl_reg <= wb_ctlout;
                        pend_dst_reg <= five_bit_muxout;
                    end else if (single_op || both_op) begin
                        align_err_reg <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (dmem_ack) begin
                        state_reg <= ST_IDLE;
                        req_reg   <= 1'b0;
                    end else begin
                        count_reg <= count_reg + CNT_W'(1);
                        if (count_reg == CNT_LAST) begin
                            state_reg       <= ST_IDLE;
                            req_reg         <= 1'b0;
                            timeout_err_reg <= 1'b1;
                        end
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    // In WAIT the retiring fields come from what was captured at access start.
    always_comb begin
        wb_load       = 1'b0;
        wb_squash     = 1'b0;
        wb_ctl_next   = wb_ctlout;
        wb_rdata_next = '0;
        wb_alu_next   = alu_result;
        wb_dst_next   = five_bit_muxout;
        if (is_idle) begin
            wb_load   = in_valid & ~start_access;
            wb_squash = single_op | both_op;
        end else begin
            wb_ctl_next   = pend_ctl_reg;
            wb_alu_next   = addr_reg;
            wb_dst_next   = pend_dst_reg;
            wb_rdata_next = we_reg ? '0 : dmem_rdata;
            wb_load       = ack_seen | expire;
            wb_squash     = expire;
        end
    end

    mem_wb_reg u_mem_wb_reg (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (wb_load),
        .squash     (wb_squash),
        .ctl_next   (wb_ctl_next),
        .rdata_next (wb_rdata_next),
        .alu_next   (wb_alu_next),
        .dst_next   (wb_dst_next),
        .valid      (wb_valid),
        .ctl        (wb_ctl),
        .rdata      (read_data),
        .alu        (alu_q),
        .dst        (write_reg)
    );
endmodule

// File: tb/tb_mem_stage.sv
// Randomized bench for mem_stage against a transaction-level model of retirement,
// stall length, error flags and the MEM/WB contents.
module tb_mem_stage;
    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [1:0]  wb_ctlout;
    logic        branch;
    logic        memread;
    logic        memwrite;
    logic        zero;
    logic [31:0] alu_result;
    logic [31:0] rdata2out;
    logic [4:0]  five_bit_muxout;
    logic        stall;
    logic        pcsrc;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;
    logic        wb_valid;
    logic [1:0]  wb_ctl;
    logic [31:0] read_data;
    logic [31:0] alu_q;
    logic [4:0]  write_reg;
    logic        align_err;
    logic        timeout_err;

    mem_stage dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .in_valid        (in_valid),
        .wb_ctlout       (wb_ctlout),
        .branch          (branch),
        .memread         (memread),
        .memwrite        (memwrite),
        .zero            (zero),
        .alu_result      (alu_result),
        .rdata2out       (rdata2out),
        .five_bit_muxout (five_bit_muxout),
        .stall           (stall),
        .pcsrc           (pcsrc),
        .dmem_req        (dmem_req),
        .dmem_we         (dmem_we),
        .dmem_addr       (dmem_addr),
        .dmem_wdata      (dmem_wdata),
        .dmem_rdata      (dmem_rdata),
        .dmem_ack        (dmem_ack),
        .wb_valid        (wb_valid),
        .wb_ctl          (wb_ctl),
        .read_data       (read_data),
        .alu_q           (alu_q),
        .write_reg       (write_reg),
        .align_err       (align_err),
        .timeout_err     (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_txn    = 0;

    // Reference model: MEM/WB contents and sticky flags as seen by the pipeline.
    logic [1:0]  exp_ctl;
    logic [31:0] exp_rd;
    logic [31:0] exp_alu;
    logic [4:0]  exp_dst;
    bit          rd_known;
    bit          ad_known;
    bit          exp_align;
    bit          exp_tmo;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_ctl   = '0;
        exp_rd    = '0;
        exp_alu   = '0;
        exp_dst   = '0;
        rd_known  = 1'b1;
        ad_known  = 1'b1;
        exp_align = 1'b0;
        exp_tmo   = 1'b0;
    endtask

    task automatic check_state(input string tag, input logic exp_valid);
        check_eq({tag, ".wb_valid"}, 32'(wb_valid), 32'(exp_valid));
        check_eq({tag, ".wb_ctl"}, 32'(wb_ctl), 32'(exp_ctl));
        check_eq({tag, ".dmem_req"}, 32'(dmem_req), 32'd0);
        check_eq({tag, ".align_err"}, 32'(align_err), 32'(exp_align));
        check_eq({tag, ".timeout_err"}, 32'(timeout_err), 32'(exp_tmo));
        if (rd_known)
            check_eq({tag, ".read_data"}, read_data, exp_rd);
        if (ad_known) begin
            check_eq({tag, ".alu_q"}, alu_q, exp_alu);
            check_eq({tag, ".write_reg"}, 32'(write_reg), 32'(exp_dst));
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, ".stall"}, 32'(stall), 32'd0);
        check_eq({tag, ".pcsrc"}, 32'(pcsrc), 32'd0);
        check_eq({tag, ".dmem_req"}, 32'(dmem_req), 32'd0);
        check_eq({tag, ".dmem_we"}, 32'(dmem_we), 32'd0);
        check_eq({tag, ".dmem_addr"}, dmem_addr, 32'd0);
        check_eq({tag, ".dmem_wdata"}, dmem_wdata, 32'd0);
        check_eq({tag, ".wb_valid"}, 32'(wb_valid), 32'd0);
        check_eq({tag, ".wb_ctl"}, 32'(wb_ctl), 32'd0);
        check_eq({tag, ".read_data"}, read_data, 32'd0);
        check_eq({tag, ".alu_q"}, alu_q, 32'd0);
        check_eq({tag, ".write_reg"}, 32'(write_reg), 32'd0);
        check_eq({tag, ".align_err"}, 32'(align_err), 32'd0);
        check_eq({tag, ".timeout_err"}, 32'(timeout_err), 32'd0);
    endtask

    // One instruction from presentation to retirement. ack_at is the WAIT cycle
    // (1..15) carrying the ack; anything else means the ack never comes.
    task automatic do_instr(input logic rd, input logic wr, input logic [1:0] ctl,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [4:0] dst, input int ack_at,
                            input logic [31:0] rdata, input logic br, input logic zr);
        bit is_mem;
        bit go;
        bit timed;
        int last;
        int n_stall;
        is_mem  = (rd ^ wr);
        go      = is_mem && (addr[1:0] == 2'b00);
        timed   = (ack_at < 1) || (ack_at > 15);
        last    = timed ? 15 : ack_at;
        n_stall = 0;

        in_valid        = 1'b1;
        memread         = rd;
        memwrite        = wr;
        wb_ctlout       = ctl;
        alu_result      = addr;
        rdata2out       = wdata;
        five_bit_muxout = dst;
        branch          = br;
        zero            = zr;

        if (go) begin
            for (int cyc = 0; cyc <= last; cyc++) begin
                // A stray ack in the IDLE issue cycle must be ignored.
                dmem_ack   = (cyc == 0) ? 1'($urandom_range(0, 1)) : (cyc == ack_at);
                dmem_rdata = (cyc > 0 && cyc == ack_at) ? rdata : $urandom();
                #1;
                if (stall) n_stall++;
                check_eq("pcsrc", 32'(pcsrc), (cyc == 0) ? 32'(br & zr) : 32'd0);
                if (cyc > 0) begin
                    check_eq("wait.dmem_req", 32'(dmem_req), 32'd1);
                    check_eq("wait.dmem_we", 32'(dmem_we), 32'(wr));
                    check_eq("wait.dmem_addr", dmem_addr, addr);
                    check_eq("wait.dmem_wdata", dmem_wdata, wdata);
                    check_eq("wait.wb_valid", 32'(wb_valid), 32'd0);
                end
                @(posedge clk);
                @(negedge clk);
            end
            check_eq("stall_cycles", 32'(n_stall), timed ? 32'd16 : 32'(ack_at));
        end else begin
            dmem_ack   = 1'($urandom_range(0, 1));
            dmem_rdata = $urandom();
            #1;
            check_eq("nomem.stall", 32'(stall), 32'd0);
            check_eq("pcsrc", 32'(pcsrc), 32'(br & zr));
            @(posedge clk);
            @(negedge clk);
        end

        in_valid = 1'b0;
        memread  = 1'b0;
        memwrite = 1'b0;
        branch   = 1'b0;
        dmem_ack = 1'b0;

        if (go && !timed) begin
            exp_ctl  = ctl;
            exp_rd   = rd ? rdata : 32'd0;
            exp_alu  = addr;
            exp_dst  = dst;
            rd_known = 1'b1;
            ad_known = 1'b1;
        end else if (go) begin
            exp_ctl  = 2'b00;
            exp_tmo  = 1'b1;
            rd_known = 1'b0;
            ad_known = 1'b0;
        end else if (is_mem) begin
            exp_ctl   = 2'b00;
            exp_rd    = 32'd0;
            exp_align = 1'b1;
            rd_known  = 1'b1;
            ad_known  = 1'b0;
        end else begin
            exp_ctl   = (rd && wr) ? 2'b00 : ctl;
            exp_rd    = 32'd0;
            exp_alu   = addr;
            exp_dst   = dst;
            exp_align = exp_align | (rd && wr);
            rd_known  = 1'b1;
            ad_known  = 1'b1;
        end
        #1;
        check_eq("retire.stall", 32'(stall), 32'd0);
        check_state("retire", 1'b1);
        n_txn++;
        $display("txn %0d: rd=%0d wr=%0d addr=%08h ack_at=%0d wb_ctl=%0d read_data=%08h",
                 n_txn, rd, wr, addr, ack_at, wb_ctl, read_data);
    endtask

    task automatic do_bubble();
        in_valid   = 1'b0;
        memread    = 1'($urandom_range(0, 1));
        memwrite   = 1'($urandom_range(0, 1));
        branch     = 1'($urandom_range(0, 1));
        zero       = 1'($urandom_range(0, 1));
        alu_result = $urandom();
        dmem_ack   = 1'($urandom_range(0, 1));
        dmem_rdata = $urandom();
        #1;
        check_eq("bubble.stall", 32'(stall), 32'd0);
        check_eq("bubble.pcsrc", 32'(pcsrc), 32'd0);
        @(posedge clk);
        @(negedge clk);
        #1;
        check_state("bubble", 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        r_rd;
        logic        r_wr;
        logic [31:0] r_addr;
        int          kind;
        int          r_ack;

        rst_n           = 1'b0;
        in_valid        = 1'b0;
        wb_ctlout       = '0;
        branch          = 1'b0;
        memread         = 1'b0;
        memwrite        = 1'b0;
        zero            = 1'b0;
        alu_result      = '0;
        rdata2out       = '0;
        five_bit_muxout = '0;
        dmem_rdata      = '0;
        dmem_ack        = 1'b0;
        model_reset();

        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check_reset_vals("reset");
        rst_n = 1'b1;

        do_instr(1'b0, 1'b0, 2'b10, 32'd7, 32'h5555, 5'd3, 0, 32'h0, 1'b0, 1'b0);
        do_instr(1'b1, 1'b0, 2'b11, 32'h100, 32'h0, 5'd9, 3, 32'hDEADBEEF, 1'b1, 1'b1);
        do_instr(1'b0, 1'b1, 2'b00, 32'h20, 32'h1234, 5'd0, 4, 32'hCAFEF00D, 1'b0, 1'b0);
        do_instr(1'b1, 1'b0, 2'b11, 32'h44, 32'h0, 5'd17, 15, 32'hA5A5A5A5, 1'b0, 1'b1);
        do_bubble();
        do_instr(1'b1, 1'b0, 2'b11, 32'h102, 32'h0, 5'd4, 2, 32'h11111111, 1'b0, 1'b0);
        do_instr(1'b1, 1'b0, 2'b11, 32'h200, 32'h0, 5'd6, 0, 32'h22222222, 1'b1, 1'b1);
        do_instr(1'b1, 1'b1, 2'b11, 32'h300, 32'h77, 5'd8, 1, 32'h33333333, 1'b0, 1'b0);
        do_bubble();

        for (int t = 0; t < 120; t++) begin
            kind = int'($urandom_range(0, 9));
            r_rd = (kind >= 4 && kind <= 6) || (kind == 9);
            r_wr = (kind >= 7);
            r_addr = $urandom();
            if ($urandom_range(0, 4) != 0) r_addr[1:0] = 2'b00;
            r_ack = ($urandom_range(0, 11) == 0) ? 0 : int'($urandom_range(1, 15));
            do_instr(r_rd, r_wr, 2'($urandom_range(0, 3)), r_addr, $urandom(),
                     5'($urandom_range(0, 31)), r_ack, $urandom(),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) do_bubble();
        end

        // Abort an outstanding load with reset, then deliver the ack late.
        in_valid        = 1'b1;
        memread         = 1'b1;
        memwrite        = 1'b0;
        alu_result      = 32'h40;
        wb_ctlout       = 2'b11;
        five_bit_muxout = 5'd12;
        dmem_ack        = 1'b0;
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        #1;
        check_eq("rst.req_before", 32'(dmem_req), 32'd1);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        memread  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_reset_vals("rst.abort");
        dmem_ack   = 1'b1;
        dmem_rdata = $urandom();
        @(posedge clk);
        @(negedge clk);
        dmem_ack = 1'b0;
        #1;
        check_reset_vals("rst.late_ack");
        model_reset();
        do_bubble();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
